// File: rtl/event_pulse_tx.sv
// Event transmitter for a toggle-based pulse synchronizer: queues event strobes
// and hands them to the receiving domain one request toggle at a time.
module event_pulse_tx #(
  parameter int PEND_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  event_i,
  input  logic                  clear_i,
  input  logic                  ack_i,
  output logic                  req_o,
  output logic [PEND_WIDTH-1:0] pending_o,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic [CNT_WIDTH-1:0]  sent_count_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic                   req_q, req_d;
  logic [PEND_WIDTH-1:0]  pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   dispatch;
  logic                   done;

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    dispatch = 1'b0;
    done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((pend_q != '0) || event_i) begin
          dispatch = 1'b1;
          req_d    = ~req_q;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ack_s == req_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear only touches the bookkeeping; an in-flight toggle still completes.
    if (clear_i) begin
      pend_d = '0;
      ovf_d  = 1'b0;
      cnt_d  = '0;
    end else begin
      if (event_i && !dispatch) begin
        if (pend_q == PEND_MAX) ovf_d = 1'b1;
        else                    pend_d = pend_q + PEND_WIDTH'(1);
      end else if (!event_i && dispatch) begin
        pend_d = pend_q - PEND_WIDTH'(1);
      end
      if (done) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    busy_d = (state_d == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ack_i};
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign req_o        = req_q;
  assign pending_o    = pend_q;
  assign busy_o       = busy_q;
  assign overflow_o   = ovf_q;
  assign sent_count_o = cnt_q;

endmodule

// File: tb/tb_event_pulse_tx.sv
// Bench for event_pulse_tx: cycle scoreboard against a behavioural model,
// a vector table for saturation/clear, and hand-written transfer sequences.
module tb_event_pulse_tx;

  localparam int PW = 4;
  localparam int SS = 2;
  localparam int CW = 16;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          event_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          ack_i;
  logic          req_o;
  logic [PW-1:0] pending_o;
  logic          busy_o;
  logic          overflow_o;
  logic [CW-1:0] sent_count_o;

  logic loop_en = 1'b0;
  logic ack_man = 1'b0;
  logic ack_rx  = 1'b0;

  int total = 0;
  int bad = 0;
  int toggles = 0;
  int peak = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  // Minimal receiver: echoes req back one cycle later, reset alongside the DUT.
  always @(posedge clk) begin
    if (rst) ack_rx <= 1'b0;
    else     ack_rx <= req_o;
  end
  assign ack_i = loop_en ? ack_rx : ack_man;

  event_pulse_tx #(.PEND_WIDTH(PW), .SYNC_STAGES(SS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .event_i(event_i), .clear_i(clear_i), .ack_i(ack_i),
    .req_o(req_o), .pending_o(pending_o), .busy_o(busy_o),
    .overflow_o(overflow_o), .sent_count_o(sent_count_o)
  );

  typedef struct {
    logic req;
    int   pend;
    logic busy;
    logic ovf;
    int   cnt;
  } exp_t;
  exp_t sbq[$];

  // Reference model state
  logic m_wait = 1'b0;
  logic m_req = 1'b0;
  logic [SS-1:0] m_sync = '0;
  int   m_pend = 0;
  logic m_ovf = 1'b0;
  int   m_cnt = 0;

  task automatic model_tick(output exp_t e);
    logic acks, disp, fin;
    if (rst) begin
      m_wait = 0; m_req = 0; m_sync = '0; m_pend = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      acks = m_sync[SS-1];
      m_sync = {m_sync[SS-2:0], ack_i};
      disp = !m_wait && (m_pend > 0 || event_i);
      fin  = m_wait && (acks == m_req);
      if (disp) begin m_req = !m_req; m_wait = 1; end
      else if (fin) m_wait = 0;
      if (clear_i) begin
        m_pend = 0; m_ovf = 0; m_cnt = 0;
      end else begin
        if (event_i && !disp && m_pend == PMAX) m_ovf = 1;
        else m_pend = m_pend + int'(event_i) - int'(disp);
        if (fin) m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
    e.req = m_req; e.pend = m_pend; e.busy = m_wait; e.ovf = m_ovf; e.cnt = m_cnt;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic ev, input logic clr, input logic r, input logic ak);
    exp_t e;
    event_i = ev; clear_i = clr; rst = r; ack_man = ak;
    #1;
    model_tick(e);
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("sb_req", req_o, e.req);
    chk("sb_pending", pending_o, e.pend);
    chk("sb_busy", busy_o, e.busy);
    chk("sb_overflow", overflow_o, e.ovf);
    chk("sb_sent", sent_count_o, e.cnt);
    if (req_o !== req_prev) toggles++;
    req_prev = req_o;
    if (int'(pending_o) > peak) peak = int'(pending_o);
  endtask

  task automatic do_reset();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic wait_idle(input string nm, input int limit, output int n);
    n = 0;
    while ((busy_o || pending_o != 0) && n < limit) begin
      step(0, 0, 0, ack_man);
      n++;
    end
    if (busy_o || pending_o != 0) begin
      total++; bad++;
      $display("FAIL %s: timeout after %0d cycles busy=%0d pending=%0d", nm, n, busy_o, pending_o);
    end
  endtask

  typedef struct {
    logic ev, clr, ak;
    int   pend;
    logic busy, ovf;
    int   cnt;
    logic req;
  } vec_t;
  vec_t vt[24];

  initial begin
    int n, t0;
    for (int k = 1; k <= 20; k++) begin
      vt[k-1].ev = 1; vt[k-1].clr = 0; vt[k-1].ak = 0;
      vt[k-1].pend = (k == 1) ? 0 : ((k - 1 > PMAX) ? PMAX : k - 1);
      vt[k-1].busy = 1; vt[k-1].ovf = (k >= 17); vt[k-1].cnt = 0; vt[k-1].req = 1;
    end
    vt[20] = '{ev:0, clr:1, ak:0, pend:0, busy:1, ovf:0, cnt:0, req:1};
    vt[21] = '{ev:0, clr:0, ak:1, pend:0, busy:1, ovf:0, cnt:0, req:1};
    vt[22] = '{ev:0, clr:0, ak:1, pend:0, busy:1, ovf:0, cnt:0, req:1};
    vt[23] = '{ev:0, clr:0, ak:1, pend:0, busy:0, ovf:0, cnt:1, req:1};

    @(posedge clk); #1;

    // Reset state
    step(1, 1, 1, 1);
    step(0, 0, 1, 0);
    chk("rst_req", req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_sent", sent_count_o, 0);
    step(0, 0, 0, 0);
    req_prev = req_o;

    // Saturation with ack held, then clear while in flight, then completion
    t0 = toggles;
    for (int i = 0; i < 24; i++) begin
      step(vt[i].ev, vt[i].clr, 0, vt[i].ak);
      chk($sformatf("vec%0d_pending", i), pending_o, vt[i].pend);
      chk($sformatf("vec%0d_busy", i), busy_o, vt[i].busy);
      chk($sformatf("vec%0d_overflow", i), overflow_o, vt[i].ovf);
      chk($sformatf("vec%0d_sent", i), sent_count_o, vt[i].cnt);
      chk($sformatf("vec%0d_req", i), req_o, vt[i].req);
    end
    chk("sat_toggles", toggles - t0, 1);

    // Single event with looped-back receiver, event in cycle 5
    loop_en = 1;
    do_reset();
    req_prev = req_o;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("single_req", req_o, 1);
    chk("single_busy", busy_o, 1);
    wait_idle("single_wait", 20, n);
    chk("single_busy_cycles", n, SS + 2);
    chk("single_sent", sent_count_o, 1);
    chk("single_pending", pending_o, 0);

    // Burst of 5
    do_reset();
    req_prev = req_o; t0 = toggles; peak = 0;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    wait_idle("burst_wait", 200, n);
    chk("burst_peak", peak, 4);
    chk("burst_toggles", toggles - t0, 5);
    chk("burst_sent", sent_count_o, 5);
    chk("burst_overflow", overflow_o, 0);

    // Reset while waiting for ack
    do_reset();
    req_prev = req_o;
    step(1, 0, 0, 0);
    chk("rstw_req_before", req_o, 1);
    step(0, 0, 1, 0);
    req_prev = req_o;
    chk("rstw_req", req_o, 0);
    chk("rstw_busy", busy_o, 0);
    chk("rstw_pending", pending_o, 0);
    step(1, 0, 0, 0);
    chk("rstw_req_again", req_o, 1);
    wait_idle("rstw_wait", 40, n);
    chk("rstw_sent", sent_count_o, 1);

    // Event + dispatch + clear at pending=3
    do_reset();
    req_prev = req_o;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("sim_pending_pre", pending_o, 3);
    n = 0;
    while (busy_o && n < 20) begin step(0, 0, 0, 0); n++; end
    chk("sim_idle_reached", busy_o, 0);
    chk("sim_pending_idle", pending_o, 3);
    t0 = toggles;
    step(1, 1, 0, 0);
    chk("sim_pending", pending_o, 0);
    chk("sim_toggle", toggles - t0, 1);
    chk("sim_busy", busy_o, 1);
    chk("sim_sent_cleared", sent_count_o, 0);
    wait_idle("sim_wait", 40, n);
    chk("sim_sent_after", sent_count_o, 1);

    // Randomised traffic with a wandering ack, checked by the scoreboard
    loop_en = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic ak;
      ak = ack_man;
      if ($urandom_range(0, 99) < 15) ak = ~ak;
      step(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 199) == 0), ak);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
